rca_seq_ctrl: RTL
=================

Name: rca_seq_ctrl

Overview:
- Word-serial sequencer that reuses one small ripple-carry adder slice (W bits, combinational, external instance) to add two N×W-bit operands.
- It latches the operands, drives the slice one W-bit chunk per cycle (LSB chunk first), and chains the carry through an internal register.
- It assembles the full sum and returns it on a done/ack handshake.
- It sits between an operand source (register file or bus) and the shared gate-level adder macro, so one adder area serves wide additions.

Parameters:
- W, 2, slice width in bits; must match the external adder instance.
- N, 4, number of slices per operation; full operand width is W*N.
- CNT_W, 2, width of the slice index counter; ceil(log2(N)), minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op_a  input  W*N  operand A; sampled with start
- op_b  input  W*N  operand B; sampled with start
- cin  input  1  carry-in to slice 0; sampled with start
- busy  output  1  high while in RUN
- done  output  1  result valid; held until ack
- ack  input  1  consumer acknowledges the result
- sum  output  W*N  assembled sum
- cout  output  1  carry out of the top slice
- add_a  output  W  chunk of A driven to the adder slice
- add_b  output  W  chunk of B driven to the adder slice
- add_ci  output  1  carry driven to the adder slice
- add_s  input  W  adder slice sum (combinational from add_a/add_b/add_ci)
- add_co  input  1  adder slice carry-out

Behaviour:
- Reset: sampled on the clk rising edge while rst_n=0, from any state including mid-RUN.
  - Next state is IDLE; idx=0, carry reg=0, a_reg=b_reg=0, sum=0, cout=0.
  - busy=0, done=0, add_a=add_b=0, add_ci=0.
  - Any in-flight operation is discarded.
- State machine IDLE/RUN/DONE:
  - IDLE: when start=1, latch op_a→a_reg, op_b→b_reg, cin→carry, set idx=0, go to RUN. When start=0, stay.
  - RUN: combinationally drive add_a=a_reg[idx*W +: W], add_b=b_reg[idx*W +: W], add_ci=carry. At each edge write sum[idx*W +: W]<=add_s, carry<=add_co, and increment idx.
  - RUN exit: when idx==N-1, write the last chunk, set cout<=add_co, go to DONE.
  - DONE: done=1; sum and cout stay stable. On ack=1, go to IDLE with done=0 in the next cycle.
- Output defaults: add_a, add_b and add_ci are 0 outside RUN.
- Latency: start sampled at edge 0 → RUN for N cycles → done=1 in the cycle after edge N. Default N=4: done rises 5 cycles after the start cycle.
- Throughput: one operation per N+2 cycles minimum (start, N RUN cycles, ack cycle).
- sum is not cleared at start. Chunks overwrite progressively, so sum is valid only while done=1.
- Ignored inputs and boundary cases:
  - start in RUN or DONE is ignored; it is not queued.
  - ack outside DONE is ignored.
  - start and ack together in DONE: ack is taken, start is ignored; the requester must reassert start in IDLE.
  - ack held high continuously: done is high for exactly 1 cycle per operation.
  - op_a/op_b may change after the start cycle without effect.
- Arithmetic: {cout,sum} = op_a + op_b + cin, computed modulo 2^(W*N+1).
- The idx counter never passes N-1; there is no wrap inside an operation.

Optional Feature:
- Macro: RCA_SEQ_SUB_EN.
- When defined:
  - Adds input sub (1 bit, sampled with start) and output ovf (1 bit, reset 0, valid with done).
  - If sub=1, b_reg latches ~op_b and carry latches 1, giving op_a − op_b; cin is ignored. cout=1 means no borrow.
  - ovf is set in DONE as the two's-complement signed overflow of the full W*N-bit result: carry into the MSB XOR cout, captured on the last RUN cycle.
- When undefined: no sub or ovf ports; add only.

Test Plan:
- W=2, N=4, op_a=0x5A, op_b=0x3C, cin=0 → add_a sequence 2,2,1,1; done 5 cycles after start; sum=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 → add_co=1 on every slice; sum=0x00, cout=1.
- op_a=0xFF, op_b=0x00, cin=1 → sum=0x00, cout=1; add_ci=1 on the first RUN cycle.
- Start 0x12+0x34; pulse start with 0xFF+0xFF during RUN; hold ack=0 for 3 cycles in DONE → sum=0x46, done held 3 cycles, second start ignored, busy=0 after ack.
- rst_n=0 on the 2nd RUN cycle of 0xAA+0x55 → next cycle IDLE, sum=0, done=0, busy=0; then 0x01+0x01 → sum=0x02.
- RCA_SEQ_SUB_EN: sub=1, 0x10−0x01 → sum=0x0F, cout=1, ovf=0; 0x80−0x01 → sum=0x7F, ovf=1.

Source files
------------

// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: word-serial W*N-bit adder that drives one external W-bit ripple-carry slice.
// Define RCA_SEQ_SUB_EN to add the sub input (A - B) and the signed-overflow output ovf.
module rca_seq_ctrl #(
  parameter int W = 2,
  parameter int N = 4,
  parameter int CNT_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W*N-1:0] op_a,
  input  logic [W*N-1:0] op_b,
  input  logic           cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic           sub,
  output logic           ovf,
`endif
  output logic           busy,
  output logic           done,
  input  logic           ack,
  output logic [W*N-1:0] sum,
  output logic           cout,
  output logic [W-1:0]   add_a,
  output logic [W-1:0]   add_b,
  output logic           add_ci,
  input  logic [W-1:0]   add_s,
  input  logic           add_co
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [W*N-1:0] a_reg, b_reg;
  logic carry;
  logic [CNT_W-1:0] idx;
  logic last;
  assign last = idx == CNT_W'(N - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    done = 1'b0;
    add_a = '0;
    add_b = '0;
    add_ci = 1'b0;
    case (state)
      IDLE: state_nxt = start ? RUN : IDLE;
      RUN: begin
        busy = 1'b1;
        add_a = a_reg[idx*W +: W];
        add_b = b_reg[idx*W +: W];
        add_ci = carry;
        state_nxt = last ? DONE : RUN;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = ack ? IDLE : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_reg <= op_a;
`ifdef RCA_SEQ_SUB_EN
      b_reg <= sub ? ~op_b : op_b;
      carry <= sub | cin;
`else
      b_reg <= op_b;
      carry <= cin;
`endif
      idx <= '0;
    end else if (state == RUN) begin
      sum[idx*W +: W] <= add_s;
      carry <= add_co;
      idx <= last ? idx : idx + 1'b1;
      if (last) cout <= add_co;
`ifdef RCA_SEQ_SUB_EN
      // carry into the MSB is recovered from the top slice's sum bit
      if (last) ovf <= add_a[W-1] ^ add_b[W-1] ^ add_s[W-1] ^ add_co;
`endif
    end
  end
endmodule
